// File: rtl/flappy_game_seq.sv
// Game-flow sequencer for the flappy-bird VGA design: game state machine,
// jump-key debouncer, frame-based physics tick enables, score/speed/high score.
module flappy_game_seq #(
  parameter int unsigned DEBOUNCE        = 500000,
  parameter int unsigned FRAMES_PER_TICK = 2,
  parameter int unsigned DYING_FRAMES    = 60,
  parameter int unsigned SPEED_INIT      = 3,
  parameter int unsigned SPEED_MAX       = 7,
  parameter int unsigned SPEEDUP_PTS     = 5
) (
  input  logic       mclk,
  input  logic       rst,
  input  logic       keyin,
  input  logic       frame_start,
  input  logic       collide,
  input  logic       passed,
  output logic [1:0] state,
  output logic       clear_world,
  output logic       bird_tick,
  output logic       pipe_tick,
  output logic       jump,
  output logic [3:0] speed,
  output logic [6:0] score,
  output logic [6:0] hiscore
);

  localparam int unsigned DBW = $clog2(DEBOUNCE);
  localparam int unsigned FW  = (FRAMES_PER_TICK > 1) ? $clog2(FRAMES_PER_TICK) : 1;
  localparam int unsigned YW  = $clog2(DYING_FRAMES + 1);
  localparam int unsigned PW  = $clog2(SPEEDUP_PTS + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_PLAY  = 2'b01,
    S_DYING = 2'b10,
    S_OVER  = 2'b11
  } state_t;

  state_t           state_q, state_d;
  logic             k_meta, k_sync, k_lvl, k_lvl_q;
  logic [DBW-1:0]   k_cnt;
  logic             kpress_c;
  logic [FW-1:0]    fcnt_q, fcnt_d;
  logic [YW-1:0]    ycnt_q, ycnt_d;
  logic [PW-1:0]    pcnt_q, pcnt_d;
  logic [6:0]       score_d, hiscore_d;
  logic [3:0]       speed_d;
  logic             clear_d, bird_d, pipe_d, jump_d;

  // Synchronizer and debouncer; level flips after DEBOUNCE disagreeing samples
  always_ff @(posedge mclk) begin
    if (rst) begin
      k_meta  <= 1'b0;
      k_sync  <= 1'b0;
      k_lvl   <= 1'b0;
      k_lvl_q <= 1'b0;
      k_cnt   <= '0;
    end else begin
      k_meta  <= keyin;
      k_sync  <= k_meta;
      k_lvl_q <= k_lvl;
      if (k_sync == k_lvl) begin
        k_cnt <= '0;
      end else if (k_cnt == DBW'(DEBOUNCE - 1)) begin
        k_lvl <= k_sync;
        k_cnt <= '0;
      end else begin
        k_cnt <= k_cnt + DBW'(1);
      end
    end
  end

  assign kpress_c = k_lvl & ~k_lvl_q;

  // Next-state, scoring and tick generation
  always_comb begin
    state_d   = state_q;
    fcnt_d    = fcnt_q;
    ycnt_d    = ycnt_q;
    pcnt_d    = pcnt_q;
    score_d   = score;
    hiscore_d = hiscore;
    speed_d   = speed;
    clear_d   = 1'b0;
    bird_d    = 1'b0;
    pipe_d    = 1'b0;
    jump_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (kpress_c) begin
          state_d = S_PLAY;
          clear_d = 1'b1;
          score_d = '0;
          speed_d = 4'(SPEED_INIT);
          pcnt_d  = '0;
        end
      end
      S_PLAY: begin
        jump_d = kpress_c;
        if (collide) begin
          state_d = S_DYING;
        end else if (passed) begin
          if (score < 7'd99) score_d = score + 7'd1;
          if (pcnt_q == PW'(SPEEDUP_PTS - 1)) begin
            pcnt_d = '0;
            if (speed < 4'(SPEED_MAX)) speed_d = speed + 4'd1;
          end else begin
            pcnt_d = pcnt_q + PW'(1);
          end
        end
      end
      S_DYING: begin
        if (frame_start) begin
          if (ycnt_q == YW'(DYING_FRAMES - 1)) begin
            state_d = S_OVER;
            if (score > hiscore) hiscore_d = score;
          end else begin
            ycnt_d = ycnt_q + YW'(1);
          end
        end
      end
      S_OVER: begin
        if (kpress_c) begin
          state_d = S_IDLE;
          clear_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A frame landing on a state change belongs to neither state
    if (state_d != state_q) begin
      fcnt_d = '0;
      ycnt_d = '0;
    end else if (frame_start && (state_q == S_PLAY || state_q == S_DYING)) begin
      if (fcnt_q == FW'(FRAMES_PER_TICK - 1)) begin
        fcnt_d = '0;
        bird_d = 1'b1;
        pipe_d = (state_q == S_PLAY);
      end else begin
        fcnt_d = fcnt_q + FW'(1);
      end
    end
  end

  always_ff @(posedge mclk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      fcnt_q      <= '0;
      ycnt_q      <= '0;
      pcnt_q      <= '0;
      score       <= '0;
      hiscore     <= '0;
      speed       <= 4'(SPEED_INIT);
      clear_world <= 1'b0;
      bird_tick   <= 1'b0;
      pipe_tick   <= 1'b0;
      jump        <= 1'b0;
    end else begin
      state_q     <= state_d;
      fcnt_q      <= fcnt_d;
      ycnt_q      <= ycnt_d;
      pcnt_q      <= pcnt_d;
      score       <= score_d;
      hiscore     <= hiscore_d;
      speed       <= speed_d;
      clear_world <= clear_d;
      bird_tick   <= bird_d;
      pipe_tick   <= pipe_d;
      jump        <= jump_d;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_flappy_game_seq.sv
// Scoreboard bench for flappy_game_seq: a rule-level game model predicts every
// cycle's outputs; a monitor compares them against the DUT.
module tb_flappy_game_seq;

  localparam int DB  = 4;
  localparam int FPT = 2;
  localparam int DYF = 3;
  localparam int SI  = 3;
  localparam int SM  = 4;
  localparam int SPP = 2;

  typedef struct packed {
    logic [1:0] st;
    logic       cw;
    logic       bt;
    logic       pt;
    logic       jp;
    logic [3:0] sp;
    logic [6:0] sc;
    logic [6:0] hi;
  } out_t;

  logic       mclk = 1'b0;
  logic       rst = 1'b1, keyin = 1'b0, frame_start = 1'b0, collide = 1'b0, passed = 1'b0;
  logic [1:0] state;
  logic       clear_world, bird_tick, pipe_tick, jump;
  logic [3:0] speed;
  logic [6:0] score, hiscore;

  flappy_game_seq #(
    .DEBOUNCE(DB), .FRAMES_PER_TICK(FPT), .DYING_FRAMES(DYF),
    .SPEED_INIT(SI), .SPEED_MAX(SM), .SPEEDUP_PTS(SPP)
  ) dut (
    .mclk(mclk), .rst(rst), .keyin(keyin), .frame_start(frame_start),
    .collide(collide), .passed(passed), .state(state),
    .clear_world(clear_world), .bird_tick(bird_tick), .pipe_tick(pipe_tick),
    .jump(jump), .speed(speed), .score(score), .hiscore(hiscore)
  );

  always #5 mclk = ~mclk;

  out_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc_n = 0;

  // Reference model: mode 0 idle, 1 play, 2 dying, 3 over
  int m_st, fc, yc, pc, sc, sp, hi, run;
  bit kd1, kd2, lvl, rose;

  task automatic model_step(input bit r, k, f, c, p, output out_t e);
    bit kp;
    int nxt;
    e = '0;
    if (r) begin
      m_st = 0; fc = 0; yc = 0; pc = 0; sc = 0; hi = 0; sp = SI;
      kd1 = 0; kd2 = 0; lvl = 0; run = 0; rose = 0;
    end else begin
      kp   = rose;
      rose = 0;
      // The key level follows the synced key after DB consecutive disagreements
      if (kd2 != lvl) begin
        run++;
        if (run == DB) begin
          lvl  = kd2;
          run  = 0;
          rose = lvl;
        end
      end else begin
        run = 0;
      end
      kd2 = kd1;
      kd1 = k;

      nxt = m_st;
      case (m_st)
        0: if (kp) begin nxt = 1; e.cw = 1; sc = 0; sp = SI; pc = 0; end
        1: begin
          e.jp = kp;
          if (c) nxt = 2;
          else if (p) begin
            sc = (sc >= 99) ? 99 : sc + 1;
            pc++;
            if (pc == SPP) begin
              pc = 0;
              sp = (sp >= SM) ? SM : sp + 1;
            end
          end
        end
        2: if (f) begin
          yc++;
          if (yc == DYF) begin
            nxt = 3;
            if (sc > hi) hi = sc;
          end
        end
        default: if (kp) begin nxt = 0; e.cw = 1; end
      endcase

      if (nxt != m_st) begin
        fc = 0;
        yc = 0;
      end else if (f && (m_st == 1 || m_st == 2)) begin
        fc++;
        if (fc == FPT) begin
          fc = 0;
          e.bt = 1;
          e.pt = (m_st == 1);
        end
      end
      m_st = nxt;
    end
    e.st = 2'(m_st);
    e.sp = 4'(sp);
    e.sc = 7'(sc);
    e.hi = 7'(hi);
  endtask

  // Drive one cycle of inputs and queue the predicted response
  task automatic cyc(input bit r, k, f, c, p);
    out_t e;
    @(negedge mclk);
    rst = r; keyin = k; frame_start = f; collide = c; passed = p;
    model_step(r, k, f, c, p, e);
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(0, 0, 0, 0, 0);
  endtask

  task automatic press();
    repeat (8) cyc(0, 1, 0, 0, 0);
    idle(8);
  endtask

  task automatic passes(input int n);
    repeat (n) begin
      cyc(0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 0);
    end
  endtask

  task automatic frames(input int n);
    repeat (n) begin
      cyc(0, 0, 1, 0, 0);
      cyc(0, 0, 0, 0, 0);
    end
  endtask

  // Monitor: every registered output is presented each cycle
  initial begin
    out_t e, g;
    forever begin
      @(posedge mclk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        g = {state, clear_world, bird_tick, pipe_tick, jump, speed, score, hiscore};
        total++;
        cyc_n++;
        if (g !== e) begin
          bad++;
          $display("FAIL outputs cycle %0d: got st=%0d cw=%0b bt=%0b pt=%0b jp=%0b sp=%0d sc=%0d hi=%0d, need st=%0d cw=%0b bt=%0b pt=%0b jp=%0b sp=%0d sc=%0d hi=%0d",
                   cyc_n, g.st, g.cw, g.bt, g.pt, g.jp, g.sp, g.sc, g.hi,
                   e.st, e.cw, e.bt, e.pt, e.jp, e.sp, e.sc, e.hi);
        end
      end
    end
  end

  initial begin
    bit ks, fp, pp, cl;
    int budget;

    // Reset then first press starts a game
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    repeat (10) cyc(0, 1, 0, 0, 0);
    idle(10);

    // Glitch must not jump; clean press jumps once
    repeat (3) cyc(0, 1, 0, 0, 0);
    idle(8);
    press();

    // Tick generation
    frames(6);

    // Scoring, speed saturation, collide beating passed
    passes(5);
    cyc(0, 0, 0, 1, 1);
    idle(2);

    // Dying into over, high score, back to idle, short second game
    frames(3);
    idle(2);
    press();
    press();
    passes(2);
    cyc(0, 0, 0, 1, 0);
    idle(1);
    frames(3);
    idle(2);

    // Reset in the middle of a game
    press();
    press();
    passes(3);
    cyc(1, 0, 0, 0, 0);
    idle(3);

    // Randomized play
    ks = 0; fp = 0; pp = 0; cl = 0;
    for (int i = 0; i < 4000; i++) begin
      bit f, p, r;
      if ($urandom_range(0, 9) == 0) ks = ~ks;
      f  = !fp && ($urandom_range(0, 3) == 0);
      p  = !pp && ($urandom_range(0, 4) == 0);
      if (!cl) cl = ($urandom_range(0, 39) == 0);
      else     cl = ($urandom_range(0, 2) != 0);
      r  = ($urandom_range(0, 699) == 0);
      cyc(r, ks, f, cl, p);
      fp = f;
      pp = p;
    end
    idle(2);

    budget = 20;
    while (exp_q.size() > 0 && budget > 0) begin
      @(posedge mclk);
      budget--;
    end
    @(posedge mclk);
    #2;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending, need 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
